// File: rtl/fip_32_sqrt.sv
// Sequential fixed-point square root: digit-by-digit restoring algorithm,
// one root bit per enabled cycle, valid/ready handshakes on both sides.
module fip_32_sqrt #(
   parameter int FRA_BITS = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic signed [31:0] i_radicand,
   output logic               o_valid,
   input  logic               i_ready,
   output logic signed [31:0] o_root,
   output logic               o_err
);

   localparam int OPW  = 32 + FRA_BITS;
   localparam int N    = OPW / 2;
   localparam int CW   = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if ((FRA_BITS % 2) != 0 || FRA_BITS < 0 || FRA_BITS > 32) begin : g_bad_fra_bits
      $error("fip_32_sqrt: FRA_BITS must be even and within 0..32");
   end

   logic [1:0]     state;
   logic [OPW-1:0] op;
   logic [N+1:0]   rem;
   logic [N-1:0]   root;
   logic [CW-1:0]  cnt;
   logic           err;

   logic [N+1:0]   rem_shift;
   logic [N+1:0]   trial;
   logic           rem_ge;
   logic [N+1:0]   rem_next;
   logic [N-1:0]   root_next;

   // One restoring step: bring down the next two operand bits and try to
   // subtract (4*root + 1); the comparison result is the next root bit.
   // NOTE: every always_comb output gets a value on every path so no latch is inferred.
   always_comb begin
      rem_shift = {rem[N-1:0], op[OPW-1 -: 2]};
      trial     = {root, 2'b01};
      rem_ge    = (rem_shift >= trial);
      rem_next  = rem_ge ? (rem_shift - trial) : rem_shift;
      root_next = {root[N-2:0], rem_ge};
   end

   // A negative radicand still passes through CALC for one cycle (doing no
   // iteration) so its result appears one cycle after the accept edge.
   // NOTE: state registers use non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         op    <= '0;
         rem   <= '0;
         root  <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else if (i_en) begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  op    <= OPW'($unsigned(i_radicand)) << FRA_BITS;
                  rem   <= '0;
                  root  <= '0;
                  cnt   <= '0;
                  err   <= i_radicand[31];
                  state <= CALC;
               end
            end
            CALC: begin
               if (err) begin
                  state <= DONE;
               end else begin
                  op   <= op << 2;
                  rem  <= rem_next;
                  root <= root_next;
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (i_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);
   assign o_root  = 32'(root);
   assign o_err   = err;

endmodule

// File: tb/tb_fip_32_sqrt.sv
// Directed bench for fip_32_sqrt: vector table for root/latency plus
// hand-written sequences for backpressure, clock-enable stalls and reset abort.
module tb_fip_32_sqrt;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic               i_en;
   logic               i_valid;
   logic               o_ready;
   logic signed [31:0] i_radicand;
   logic               o_valid;
   logic               i_ready;
   logic signed [31:0] o_root;
   logic               o_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] rad;
      logic [31:0] exp_root;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   fip_32_sqrt #(.FRA_BITS(16)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_radicand (i_radicand),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_root     (o_root),
      .o_err      (o_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start(input logic [31:0] rad, input string name);
      int w;
      w = 0;
      while (!o_ready && w < 100) begin
         tick();
         w++;
      end
      check({name, "_ready_before_accept"}, 32'(o_ready), 32'd1);
      i_valid    = 1'b1;
      i_radicand = rad;
      tick();
      i_valid    = 1'b0;
      i_radicand = 32'h5A5A_A5A5;
   endtask

   // Called just after the accept edge; returns edges until o_valid, or -1.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int c = 0; c <= 80; c++) begin
         if (o_valid) begin
            lat = c;
            break;
         end
         tick();
      end
   endtask

   task automatic handshake(input string name);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check({name, "_valid_after_hs"}, 32'(o_valid), 32'd0);
      check({name, "_ready_after_hs"}, 32'(o_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int lat;
      start(v.rad, name);
      wait_valid(lat);
      check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
      check({name, "_root"}, o_root, v.exp_root);
      check({name, "_err"}, 32'(o_err), 32'(v.exp_err));
      handshake(name);
   endtask

   vec_t vecs[10];

   initial begin
      int lat;

      vecs[0] = '{32'h0004_0000, 32'h0002_0000, 1'b0, 24};
      vecs[1] = '{32'h0002_0000, 32'h0001_6A09, 1'b0, 24};
      vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 24};
      vecs[3] = '{32'h0000_0001, 32'h0000_0100, 1'b0, 24};
      vecs[4] = '{32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0, 24};
      vecs[5] = '{32'hFFFF_0000, 32'h0000_0000, 1'b1, 1};
      vecs[6] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 24};
      vecs[7] = '{32'h0003_0000, 32'h0001_BB67, 1'b0, 24};
      vecs[8] = '{32'h0000_0004, 32'h0000_0200, 1'b0, 24};
      vecs[9] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1};

      i_rst      = 1'b1;
      i_en       = 1'b1;
      i_valid    = 1'b0;
      i_ready    = 1'b0;
      i_radicand = '0;
      tick();
      tick();
      i_rst = 1'b0;
      check("reset_ready", 32'(o_ready), 32'd1);
      check("reset_valid", 32'(o_valid), 32'd0);
      check("reset_root", o_root, 32'd0);
      check("reset_err", 32'(o_err), 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure: result held 10 cycles, new i_valid ignored meanwhile.
      start(32'h0004_0000, "bp");
      wait_valid(lat);
      check("bp_latency", 32'(lat), 32'd24);
      i_valid    = 1'b1;
      i_radicand = 32'h0009_0000;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("bp_valid_c%0d", c), 32'(o_valid), 32'd1);
         check($sformatf("bp_root_c%0d", c), o_root, 32'h0002_0000);
         check($sformatf("bp_err_c%0d", c), 32'(o_err), 32'd0);
         check($sformatf("bp_ready_c%0d", c), 32'(o_ready), 32'd0);
      end
      i_valid = 1'b0;
      handshake("bp");
      tick();
      check("bp_idle_hold", 32'(o_ready), 32'd1);

      // Clock-enable stall of 5 cycles after the 10th iteration.
      start(32'h0009_0000, "en");
      lat = -1;
      for (int c = 0; c <= 80; c++) begin
         if (o_valid) begin
            lat = c;
            break;
         end
         tick();
         if (c + 1 == 10) i_en = 1'b0;
         if (c + 1 == 15) i_en = 1'b1;
      end
      check("en_latency", 32'(lat), 32'd29);
      check("en_root", o_root, 32'h0003_0000);
      check("en_err", 32'(o_err), 32'd0);
      i_en    = 1'b0;
      i_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("en_done_hold_c%0d", c), 32'(o_valid), 32'd1);
      end
      i_ready = 1'b0;
      i_en    = 1'b1;
      handshake("en");

      // Reset at iteration 10 aborts the operation.
      start(32'h0004_0000, "rst");
      for (int c = 0; c < 10; c++) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_root", o_root, 32'd0);
      lat = 0;
      for (int c = 0; c < 30; c++) begin
         if (o_valid) lat = 1;
         tick();
      end
      check("rst_never_valid", 32'(lat), 32'd0);
      run_vec('{32'h0010_0000, 32'h0004_0000, 1'b0, 24}, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
